// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, operand/result widths and the queued command format.
package alu_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_XOR = 2'd3
    } opcode_e;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        opcode_e           op;
    } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU producing a 16-bit result.
module alu
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [1:0]        op,
    output logic [RES_W-1:0]  y
);

    always_comb begin
        y = '0;
        case (opcode_e'(op))
            OP_ADD:  y = RES_W'(a) + RES_W'(b);
            OP_SUB:  y = RES_W'(a) - RES_W'(b);
            OP_MUL:  y = RES_W'(a) * RES_W'(b);
            OP_XOR:  y = RES_W'(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
    import alu_pkg::*;
#(
    parameter type T     = alu_cmd_t,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  T            din,
    output T            dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    T            mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage: queues ALU commands, drives the ALU from the queue head and
// registers each result with an in-order sequence tag.
//
//   state    | meaning
//   ST_EMPTY | result register holds nothing (out_valid=0)
//   ST_FULL  | result register holds an unconsumed result (out_valid=1)
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [1:0]               in_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [1:0]               alu_op,
    input  logic [15:0]              alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_y,
    output logic [1:0]               out_op,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH)+1:0] pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH) + 2;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    alu_cmd_t         head;
    alu_cmd_t         fifo_din;
    logic             fifo_full, fifo_empty, push, issue;
    logic [CW-1:0]    fifo_count;
    logic [TAG_W-1:0] tag_cnt;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign fifo_din = '{a: in_a, b: in_b, op: opcode_e'(in_op)};

    sync_fifo #(.T(alu_cmd_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign alu_a  = fifo_empty ? '0 : head.a;
    assign alu_b  = fifo_empty ? '0 : head.b;
    assign alu_op = fifo_empty ? OP_ADD : head.op;

    assign out_valid = (state_q == ST_FULL);
    assign issue     = !fifo_empty && (!out_valid || out_ready);
    assign pending   = PW'(fifo_count) + PW'(out_valid);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (issue) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !issue) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_y   <= '0;
            out_op  <= OP_ADD;
            out_tag <= '0;
            tag_cnt <= '0;
        end else if (issue) begin
            out_y   <= alu_y;
            out_op  <= head.op;
            out_tag <= tag_cnt;
            tag_cnt <= tag_cnt + TAG_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Integration bench: alu_cmd_sequencer driving the ALU, directed steps plus a randomized scoreboard run.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b, alu_a, alu_b;
    logic [1:0]  in_op, alu_op, out_op;
    logic [15:0] alu_y, out_y;
    logic [3:0]  out_tag;
    logic [3:0]  pending;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] y;
        logic [1:0]  op;
        logic [3:0]  tag;
    } res_t;

    res_t sb[$];

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_tag   (out_tag),
        .pending   (pending)
    );

    alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [15:0] model_y(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            2'd0:    return wa + wb;
            2'd1:    return wa - wb;
            2'd2:    return wa * wb;
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    initial begin
        logic       acc, fin, fout;
        logic [3:0] tag_m;
        int         sent, recv, cyc;
        res_t       got, exp_r;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;

        // reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1: single ADD
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_op = OP_ADD;
        tick();
        in_valid = 1'b0;
        chk("add_not_yet_valid", 32'(out_valid), 32'd0);
        chk("add_pending_1", 32'(pending), 32'd1);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_y", 32'(out_y), 32'd300);
        chk("add_op", 32'(out_op), 32'd0);
        chk("add_tag", 32'(out_tag), 32'd0);
        tick();
        chk("add_valid_one_cycle", 32'(out_valid), 32'd0);

        // 2: back-to-back SUB, MUL, XOR
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd5; in_op = OP_SUB;
        tick();
        in_a = 8'd255; in_b = 8'd255; in_op = OP_MUL;
        tick();
        chk("b2b_sub_y", 32'(out_y), 32'hFFFE);
        chk("b2b_sub_tag", 32'(out_tag), 32'd0);
        in_a = 8'hF0; in_b = 8'h3C; in_op = OP_XOR;
        tick();
        in_valid = 1'b0;
        chk("b2b_mul_y", 32'(out_y), 32'hFE01);
        chk("b2b_mul_tag", 32'(out_tag), 32'd1);
        chk("b2b_mul_op", 32'(out_op), 32'd2);
        tick();
        chk("b2b_xor_y", 32'(out_y), 32'h00CC);
        chk("b2b_xor_tag", 32'(out_tag), 32'd2);
        chk("b2b_xor_valid", 32'(out_valid), 32'd1);
        tick();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // 3: back-pressure fills FIFO plus output register
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'd1; in_op = OP_ADD;
            #1;
            chk("bp_in_ready", 32'(in_ready), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) tick();
        end
        chk("bp_pending", 32'(pending), 32'd5);
        chk("bp_hold_y", 32'(out_y), 32'd2);
        tick();
        chk("bp_stable_y", 32'(out_y), 32'd2);
        chk("bp_stable_tag", 32'(out_tag), 32'd0);
        chk("bp_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            chk("bp_drain_y", 32'(out_y), 32'(k + 2));
            chk("bp_drain_tag", 32'(out_tag), 32'(k));
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_sixth_taken", 32'(in_valid), 32'd0);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_pending", 32'(pending), 32'd0);

        // 4: tag wrap over 17 results
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1; in_a = 8'(k); in_b = 8'd0; in_op = OP_XOR;
            tick();
            if (k > 0) begin
                chk("wrap_tag", 32'(out_tag), 32'((k - 1) % 16));
                chk("wrap_y", 32'(out_y), 32'(k - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_tag17", 32'(out_tag), 32'd0);
        chk("wrap_y17", 32'(out_y), 32'd16);

        // 5: reset mid-operation
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 8'(k + 10); in_b = 8'd1; in_op = OP_SUB;
            tick();
        end
        in_valid = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_pending", 32'(pending), 32'd4);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_valid", 32'(out_valid), 32'd0);
        chk("mid_after_pending", 32'(pending), 32'd0);
        chk("mid_after_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_op = OP_ADD;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_first_valid", 32'(out_valid), 32'd1);
        chk("mid_first_tag", 32'(out_tag), 32'd0);
        chk("mid_first_y", 32'(out_y), 32'd18);

        // 6: random valid/ready against a scoreboard
        do_reset();
        tag_m = '0; sent = 0; recv = 0; cyc = 0;
        while (recv < 1000 && cyc < 20000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_a  = 8'($urandom);
                in_b  = 8'($urandom);
                in_op = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                chk("rnd_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_r = sb.pop_front();
                    got   = '{y: out_y, op: out_op, tag: out_tag};
                    chk("rnd_result", 32'(got), 32'(exp_r));
                end
                recv++;
            end
            if (fin) begin
                sb.push_back('{y: model_y(in_a, in_b, in_op), op: in_op, tag: tag_m});
                tag_m = tag_m + 4'd1;
                sent++;
            end
            tick();
            if (fin) in_valid = 1'b0;
            cyc++;
        end
        chk("rnd_all_received", 32'(recv), 32'd1000);
        chk("rnd_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
